// File: rtl/clk_gen_core_if.sv
// clk_gen_core_if: control/status bundle for the programmable clock generator.
// master = controller side (drives run enable and half-period loads),
// slave  = generator side (drives the generated clock, edge strobes and period count).
interface clk_gen_core_if #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned PCNT_W = 16
);
  logic              en;
  logic              hp_ld;
  logic [CNT_W-1:0]  hp_in;
  logic              clk_out;
  logic              rise;
  logic              fall;
  logic [PCNT_W-1:0] period_cnt;

  modport master (
    output en, hp_ld, hp_in,
    input  clk_out, rise, fall, period_cnt
  );

  modport slave (
    input  en, hp_ld, hp_in,
    output clk_out, rise, fall, period_cnt
  );
endinterface

// File: rtl/clk_gen_core.sv
// clk_gen_core: programmable 50% duty-cycle clock generator.
// Toggles clk_out every half-period reference cycles, emits one-cycle rise/fall
// strobes alongside the new clk_out level, and parks low when disabled.
// Half-period updates are deferred to the next toggle so no phase is ever cut short.
// Optional feature macro: CLK_GEN_CORE_PERIOD_CNT_EN builds the completed-period
// counter; without it period_cnt is tied to zero.
module clk_gen_core #(
  parameter int unsigned HALF_PERIOD = 1,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned PCNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  clk_gen_core_if.slave  bus
);

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hp_active;
  logic [CNT_W-1:0] r_hp_pending;
  logic             r_pend_valid;
  logic             r_rise;
  logic             r_fall;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_hp_active_nxt;
  logic [CNT_W-1:0] w_hp_pending_nxt;
  logic             w_pend_valid_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  logic             w_run;
  logic             w_tc;
  logic [CNT_W-1:0] w_hp_in_sat;
  logic [CNT_W-1:0] w_hp_next_phase;

  // Running while enabled or while a high phase is still in progress, so the
  // generator can only stop after completing a high phase.
  assign w_run           = bus.en | (r_state == ST_HIGH);
  assign w_tc            = (r_cnt == '0);
  assign w_hp_in_sat     = (bus.hp_in == '0) ? CNT_W'(1) : bus.hp_in;
  assign w_hp_next_phase = r_pend_valid ? r_hp_pending : r_hp_active;

  // State register: phase, counter, half-period bookkeeping and edge strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_LOW;
      r_cnt        <= CNT_W'(HALF_PERIOD - 1);
      r_hp_active  <= CNT_W'(HALF_PERIOD);
      r_hp_pending <= CNT_W'(HALF_PERIOD);
      r_pend_valid <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hp_active  <= w_hp_active_nxt;
      r_hp_pending <= w_hp_pending_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_rise       <= w_rise_nxt;
      r_fall       <= w_fall_nxt;
    end
  end

  // Next-state logic: parked hold/immediate load, or count down and toggle at terminal count.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_hp_active_nxt  = r_hp_active;
    w_hp_pending_nxt = r_hp_pending;
    w_pend_valid_nxt = r_pend_valid;
    w_rise_nxt       = 1'b0;
    w_fall_nxt       = 1'b0;
    if (!w_run) begin
      // Parked low: a load takes effect at once and supersedes any stale pending value.
      if (bus.hp_ld) begin
        w_hp_active_nxt  = w_hp_in_sat;
        w_cnt_nxt        = w_hp_in_sat - CNT_W'(1);
        w_pend_valid_nxt = 1'b0;
      end else begin
        w_cnt_nxt = r_hp_active - CNT_W'(1);
      end
    end else begin
      if (bus.hp_ld) begin
        w_hp_pending_nxt = w_hp_in_sat;
        w_pend_valid_nxt = 1'b1;
      end
      if (!w_tc) begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end else begin
        w_state_nxt     = (r_state == ST_HIGH) ? ST_LOW : ST_HIGH;
        w_rise_nxt      = (r_state == ST_LOW);
        w_fall_nxt      = (r_state == ST_HIGH);
        w_hp_active_nxt = w_hp_next_phase;
        w_cnt_nxt       = w_hp_next_phase - CNT_W'(1);
        // A load landing on the toggle cycle stays pending for the following toggle.
        if (!bus.hp_ld) begin
          w_pend_valid_nxt = 1'b0;
        end
      end
    end
  end

`ifdef CLK_GEN_CORE_PERIOD_CNT_EN
  logic [PCNT_W-1:0] r_period_cnt;

  // Completed-period counter: advances together with the fall strobe, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
    end else if (w_fall_nxt) begin
      r_period_cnt <= r_period_cnt + PCNT_W'(1);
    end
  end
`endif

  // Output logic: every output is a direct register view.
  always_comb begin
    bus.clk_out = (r_state == ST_HIGH);
    bus.rise    = r_rise;
    bus.fall    = r_fall;
`ifdef CLK_GEN_CORE_PERIOD_CNT_EN
    bus.period_cnt = r_period_cnt;
`else
    bus.period_cnt = '0;
`endif
  end

endmodule

// File: tb/tb_clk_gen_core.sv
// tb_clk_gen_core: directed test of clk_gen_core with an edge-event scoreboard.
// Expected rise/fall events (cycle, kind, period count) are queued as stimulus
// is applied and retired by a per-cycle monitor.
module tb_clk_gen_core;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PCNT_W = 4;
`ifdef CLK_GEN_CORE_PERIOD_CNT_EN
  localparam bit PCNT_ON = 1'b1;
`else
  localparam bit PCNT_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  clk_gen_core_if #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) bus ();

  clk_gen_core #(
    .HALF_PERIOD(3),
    .CNT_W      (CNT_W),
    .PCNT_W     (PCNT_W)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int unsigned       cyc;
    logic              rise;
    logic [PCNT_W-1:0] pcnt;
  } ev_t;

  ev_t               sb[$];
  int unsigned       checks   = 0;
  int unsigned       errors   = 0;
  int unsigned       cyc      = 0;
  int unsigned       base     = 0;
  logic [PCNT_W-1:0] exp_pcnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_rise(input int unsigned c);
    ev_t e;
    e.cyc  = c;
    e.rise = 1'b1;
    e.pcnt = PCNT_ON ? exp_pcnt : '0;
    sb.push_back(e);
  endfunction

  function automatic void push_fall(input int unsigned c);
    ev_t e;
    exp_pcnt = exp_pcnt + PCNT_W'(1);
    e.cyc  = c;
    e.rise = 1'b0;
    e.pcnt = PCNT_ON ? exp_pcnt : '0;
    sb.push_back(e);
  endfunction

  task automatic mon();
    ev_t e;
    if (bus.rise === 1'b1 || bus.fall === 1'b1) begin
      chk("rise_fall_exclusive", 32'(bus.rise & bus.fall), 32'd0);
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_edge: cyc %0d observed rise=%0b fall=%0b, expected no edge",
               cyc, bus.rise, bus.fall);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("edge_cycle", 32'(cyc), 32'(e.cyc));
        chk("edge_is_rise", 32'(bus.rise), 32'(e.rise));
        chk("clk_out_at_edge", 32'(bus.clk_out), 32'(e.rise));
        chk("period_cnt_at_edge", 32'(bus.period_cnt), 32'(e.pcnt));
      end
    end else if (sb.size() != 0) begin
      checks++;
      assert (sb[0].cyc > cyc)
      else begin
        errors++;
        $error("FAIL missed_edge: cyc %0d observed no edge, expected rise=%0b at cyc %0d",
               cyc, sb[0].rise, sb[0].cyc);
      end
      if (sb[0].cyc <= cyc) void'(sb.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mon();
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.en    = 1'b0;
    bus.hp_ld = 1'b0;
    bus.hp_in = '0;

    // Reset values
    #12;
    chk("rst_clk_out", 32'(bus.clk_out), 32'd0);
    chk("rst_rise", 32'(bus.rise), 32'd0);
    chk("rst_fall", 32'(bus.fall), 32'd0);
    chk("rst_period_cnt", 32'(bus.period_cnt), 32'd0);

    // Release with en=1: first rise on the 3rd edge, then async reset mid-high
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    bus.en = 1'b1;
    base   = cyc;
    push_rise(base + 3);
    run(3);
    chk("pre_rst_clk_out_high", 32'(bus.clk_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_clk_out", 32'(bus.clk_out), 32'd0);
    chk("async_rst_rise", 32'(bus.rise), 32'd0);
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    base  = cyc;
    push_rise(base + 3);
    push_fall(base + 6);
    run(6);
    chk("sb_empty_after_restart", 32'(sb.size()), 32'd0);
    chk("pcnt_before_reset", 32'(bus.period_cnt), PCNT_ON ? 32'd1 : 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_period_cnt", 32'(bus.period_cnt), 32'd0);
    exp_pcnt = '0;

    // H=1 loaded while parked, 20 cycles -> 10 rises, 10 falls
    bus.en    = 1'b0;
    bus.hp_ld = 1'b1;
    bus.hp_in = CNT_W'(1);
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    tick();
    bus.hp_ld = 1'b0;
    bus.en    = 1'b1;
    base      = cyc;
    for (int unsigned k = 0; k < 10; k++) begin
      push_rise(base + 1 + 2 * k);
      push_fall(base + 2 + 2 * k);
    end
    run(20);
    chk("h1_sb_empty", 32'(sb.size()), 32'd0);
    chk("h1_period_cnt", 32'(bus.period_cnt), PCNT_ON ? 32'd10 : 32'd0);

    // H=3, then load 5 one cycle into the second high phase
    bus.en    = 1'b0;
    bus.hp_ld = 1'b1;
    bus.hp_in = CNT_W'(3);
    tick();
    bus.hp_ld = 1'b0;
    bus.en    = 1'b1;
    base      = cyc;
    push_rise(base + 3);
    push_fall(base + 6);
    push_rise(base + 9);
    push_fall(base + 12);
    push_rise(base + 17);
    push_fall(base + 22);
    push_rise(base + 27);
    push_fall(base + 32);
    run(9);
    bus.hp_ld = 1'b1;
    bus.hp_in = CNT_W'(5);
    tick();
    bus.hp_ld = 1'b0;
    run(22);
    chk("h3to5_sb_empty", 32'(sb.size()), 32'd0);
    chk("h3to5_clk_out_low", 32'(bus.clk_out), 32'd0);

    // H=4, drop en one cycle into high: completes then parks low
    bus.en    = 1'b0;
    bus.hp_ld = 1'b1;
    bus.hp_in = CNT_W'(4);
    tick();
    bus.hp_ld = 1'b0;
    bus.en    = 1'b1;
    base      = cyc;
    push_rise(base + 4);
    push_fall(base + 8);
    run(4);
    bus.en = 1'b0;
    run(16);
    chk("parked_sb_empty", 32'(sb.size()), 32'd0);
    chk("parked_clk_out_low", 32'(bus.clk_out), 32'd0);
    bus.en = 1'b1;
    base   = cyc;
    push_rise(base + 4);
    push_fall(base + 8);
    run(8);
    chk("resume_sb_empty", 32'(sb.size()), 32'd0);

    // hp_in=0 behaves as H=1; 16 periods wrap the 4-bit period counter
    bus.en    = 1'b0;
    bus.hp_ld = 1'b1;
    bus.hp_in = '0;
    tick();
    bus.hp_ld = 1'b0;
    bus.en    = 1'b1;
    base      = cyc;
    for (int unsigned k = 0; k < 16; k++) begin
      push_rise(base + 1 + 2 * k);
      push_fall(base + 2 + 2 * k);
    end
    run(32);
    chk("h0_sb_empty", 32'(sb.size()), 32'd0);
    chk("h0_period_cnt_wrapped", 32'(bus.period_cnt), 32'(exp_pcnt & {PCNT_W{PCNT_ON}}));

    bus.en = 1'b0;
    run(4);
    chk("final_clk_out_low", 32'(bus.clk_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
